// File: rtl/urna_pkg.sv
// Shared types and helpers for the ballot-box session controller.
// Holds the state encoding, the default candidate codes and the vote decoder.
package urna_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_CLEAR  = 3'b001,
    ST_VOTING = 3'b010,
    ST_LATCH  = 3'b011,
    ST_REPORT = 3'b100
  } estado_t;

  typedef enum logic [1:0] {
    CLS_C1   = 2'd0,
    CLS_C2   = 2'd1,
    CLS_NULL = 2'd2
  } classe_t;

  localparam logic [3:0] VOTO_A_DEF = 4'b1010;
  localparam logic [3:0] VOTO_B_DEF = 4'b1111;

  // swap exchanges the two candidates; any unknown code is a null vote
  function automatic classe_t decodifica(input logic [3:0] voto, input logic swap,
                                         input logic [3:0] cod_a, input logic [3:0] cod_b);
    classe_t c;
    if (voto == cod_a)      c = swap ? CLS_C2 : CLS_C1;
    else if (voto == cod_b) c = swap ? CLS_C1 : CLS_C2;
    else                    c = CLS_NULL;
    return c;
  endfunction

endpackage

// File: rtl/urna_if.sv
// Booth/tally-side signal bundle of the ballot-box controller.
// master drives session control and booth requests; slave is the controller.
interface urna_if #(parameter int N = 2);
  logic           abrir;
  logic           finish;
  logic [N-1:0]   valid;
  logic [4*N-1:0] voto;
  logic [N-1:0]   swap;
  logic [N-1:0]   ack;
  logic           inc_c1;
  logic           inc_c2;
  logic           inc_null;
  logic           clear_tally;
  logic           latch_totals;
  logic [2:0]     estado;
  logic [7:0]     cont_votos;
  logic           urna_cheia;

  modport master (
    output abrir, finish, valid, voto, swap,
    input  ack, inc_c1, inc_c2, inc_null, clear_tally, latch_totals,
           estado, cont_votos, urna_cheia
  );

  modport slave (
    input  abrir, finish, valid, voto, swap,
    output ack, inc_c1, inc_c2, inc_null, clear_tally, latch_totals,
           estado, cont_votos, urna_cheia
  );
endinterface

// File: rtl/urna_arbitro_rr.sv
// Combinational round-robin picker: first eligible index at or after the pointer.
// The pointer register is owned by the caller.
module urna_arbitro_rr #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elegivel_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!any_o && elegivel_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/urna_controlador.sv
// Election session sequencer plus round-robin booth arbiter feeding one tally datapath.
// A granted vote yields ack and one registered inc_* pulse in the following cycle.
module urna_controlador
  import urna_pkg::*;
#(
  parameter int         NUM_CABINES = 2,
  parameter logic [7:0] MAX_VOTOS   = 8'd255,
  parameter logic [3:0] VOTO_A      = VOTO_A_DEF,
  parameter logic [3:0] VOTO_B      = VOTO_B_DEF
) (
  input logic clock,
  input logic reset,
  urna_if.slave bus
);

  localparam int IW = (NUM_CABINES > 1) ? $clog2(NUM_CABINES) : 1;

  estado_t              state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_CABINES-1:0] armed_q, armed_d;
  logic [NUM_CABINES-1:0] ack_q, ack_d;
  logic                 inc_c1_q, inc_c1_d;
  logic                 inc_c2_q, inc_c2_d;
  logic                 inc_null_q, inc_null_d;
  logic                 clear_q, clear_d;
  logic                 latch_q, latch_d;
  logic [7:0]           cont_q, cont_d;

  logic                   cheia;
  logic [NUM_CABINES-1:0] elegivel;
  logic [NUM_CABINES-1:0] grant;
  logic [IW-1:0]          gnt_idx;
  logic                   any_grant;
  classe_t                classe;

  assign cheia    = (cont_q == MAX_VOTOS);
  assign elegivel = bus.valid & armed_q &
                    {NUM_CABINES{(state_q == ST_VOTING) && !cheia}};

  urna_arbitro_rr #(.N(NUM_CABINES), .IW(IW)) u_arbitro (
    .elegivel_i (elegivel),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .idx_o      (gnt_idx),
    .any_o      (any_grant)
  );

  assign classe = decodifica(bus.voto[4*int'(gnt_idx) +: 4], bus.swap[gnt_idx], VOTO_A, VOTO_B);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    armed_d    = (armed_q | ~bus.valid) & ~grant;
    ack_d      = grant;
    inc_c1_d   = any_grant && (classe == CLS_C1);
    inc_c2_d   = any_grant && (classe == CLS_C2);
    inc_null_d = any_grant && (classe == CLS_NULL);
    cont_d     = cont_q;

    case (state_q)
      ST_IDLE:   if (bus.abrir) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_VOTING;
      ST_VOTING: if (bus.finish) state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_REPORT;
      ST_REPORT: if (bus.abrir) state_d = ST_CLEAR;
      default:   state_d = ST_IDLE;
    endcase

    if (any_grant)
      ptr_d = (gnt_idx == IW'(NUM_CABINES - 1)) ? '0 : gnt_idx + IW'(1);

    // count is zeroed on entry so it already reads 0 during the CLEAR cycle
    if (state_d == ST_CLEAR) cont_d = '0;
    else if (any_grant)      cont_d = cont_q + 8'd1;

    clear_d = (state_d == ST_CLEAR);
    latch_d = (state_d == ST_LATCH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      armed_q    <= '0;
      ack_q      <= '0;
      inc_c1_q   <= 1'b0;
      inc_c2_q   <= 1'b0;
      inc_null_q <= 1'b0;
      clear_q    <= 1'b0;
      latch_q    <= 1'b0;
      cont_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      armed_q    <= armed_d;
      ack_q      <= ack_d;
      inc_c1_q   <= inc_c1_d;
      inc_c2_q   <= inc_c2_d;
      inc_null_q <= inc_null_d;
      clear_q    <= clear_d;
      latch_q    <= latch_d;
      cont_q     <= cont_d;
    end
  end

  assign bus.estado       = state_q;
  assign bus.ack          = ack_q;
  assign bus.inc_c1       = inc_c1_q;
  assign bus.inc_c2       = inc_c2_q;
  assign bus.inc_null     = inc_null_q;
  assign bus.clear_tally  = clear_q;
  assign bus.latch_totals = latch_q;
  assign bus.cont_votos   = cont_q;
  assign bus.urna_cheia   = cheia;

endmodule

// File: tb/tb_urna_controlador.sv
// Bench for urna_controlador: directed session scenarios then random traffic,
// all checked against a behavioural session/vote model and a tally that consumes the pulses.
module tb_urna_controlador;

  localparam int         NC   = 2;
  localparam logic [7:0] MAXV = 8'd3;
  localparam logic [3:0] CA   = 4'b1010;
  localparam logic [3:0] CB   = 4'b1111;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  urna_if #(.N(NC)) bus();

  urna_controlador #(.NUM_CABINES(NC), .MAX_VOTOS(MAXV), .VOTO_A(CA), .VOTO_B(CB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: phase 0 idle,1 clear,2 voting,3 latch,4 report
  int m_ph, m_ptr, m_cnt;
  bit m_rdy[NC];
  int m_tot[3];
  int e_ack, e_c1, e_c2, e_nul, e_clr, e_lat;
  // tally fed by the DUT pulses, plus pulse counters for directed checks
  int t_cnt[3], t_tc[3];
  int n_ack[NC], n_inc[3];

  function automatic int classify(input logic [3:0] code, input logic sw);
    if (code == CA) return sw ? 1 : 0;
    if (code == CB) return sw ? 0 : 1;
    return 2;
  endfunction

  task automatic model_update();
    int win, nph, c;
    if (reset) begin
      m_ph = 0; m_ptr = 0; m_cnt = 0;
      for (int i = 0; i < NC; i++) m_rdy[i] = 1'b0;
      e_ack = 0; e_c1 = 0; e_c2 = 0; e_nul = 0; e_clr = 0; e_lat = 0;
      return;
    end
    win = -1;
    if (m_ph == 2 && m_cnt < int'(MAXV))
      for (int k = 0; k < NC; k++)
        if (win < 0 && bus.valid[(m_ptr + k) % NC] && m_rdy[(m_ptr + k) % NC]) win = (m_ptr + k) % NC;
    for (int i = 0; i < NC; i++) if (!bus.valid[i]) m_rdy[i] = 1'b1;
    e_ack = 0; e_c1 = 0; e_c2 = 0; e_nul = 0;
    if (win >= 0) begin
      m_rdy[win] = 1'b0;
      e_ack = 1 << win;
      c = classify(bus.voto[4*win +: 4], bus.swap[win]);
      if (c == 0) e_c1 = 1; else if (c == 1) e_c2 = 1; else e_nul = 1;
      m_tot[c]++;
      m_ptr = (win + 1) % NC;
    end
    case (m_ph)
      0: nph = bus.abrir ? 1 : 0;
      1: nph = 2;
      2: nph = bus.finish ? 3 : 2;
      3: nph = 4;
      default: nph = bus.abrir ? 1 : 4;
    endcase
    if (nph == 1) begin
      m_cnt = 0;
      for (int k = 0; k < 3; k++) m_tot[k] = 0;
    end else if (win >= 0) m_cnt++;
    e_clr = (nph == 1);
    e_lat = (nph == 3);
    m_ph  = nph;
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    chk("estado", 32'(bus.estado), e_clr ? 1 : (e_lat ? 3 : m_ph));
    chk("ack", 32'(bus.ack), e_ack);
    chk("inc_c1", 32'(bus.inc_c1), e_c1);
    chk("inc_c2", 32'(bus.inc_c2), e_c2);
    chk("inc_null", 32'(bus.inc_null), e_nul);
    chk("clear_tally", 32'(bus.clear_tally), e_clr);
    chk("latch_totals", 32'(bus.latch_totals), e_lat);
    chk("cont_votos", 32'(bus.cont_votos), m_cnt);
    chk("urna_cheia", 32'(bus.urna_cheia), (m_cnt == int'(MAXV)) ? 1 : 0);
    for (int i = 0; i < NC; i++) if (bus.ack[i]) n_ack[i]++;
    if (bus.clear_tally) for (int k = 0; k < 3; k++) begin t_cnt[k] = 0; t_tc[k] = 0; end
    if (bus.inc_c1)   begin t_cnt[0]++; n_inc[0]++; end
    if (bus.inc_c2)   begin t_cnt[1]++; n_inc[1]++; end
    if (bus.inc_null) begin t_cnt[2]++; n_inc[2]++; end
    if (bus.latch_totals) begin
      for (int k = 0; k < 3; k++) t_tc[k] = t_cnt[k];
      chk("tc_c1", t_tc[0], m_tot[0]);
      chk("tc_c2", t_tc[1], m_tot[1]);
      chk("tc_null", t_tc[2], m_tot[2]);
    end
  endtask

  task automatic booth(input int i, input logic v, input logic [3:0] code, input logic sw);
    bus.valid[i]        = v;
    bus.voto[4*i +: 4]  = code;
    bus.swap[i]         = sw;
  endtask

  task automatic press(input int i, input logic [3:0] code, input logic sw);
    booth(i, 1'b1, code, sw);
    repeat (2) step();
    booth(i, 1'b0, code, sw);
    step();
  endtask

  int a0, c0, c1b, nb;

  initial begin
    for (int k = 0; k < 3; k++) begin m_tot[k] = 0; t_cnt[k] = 0; t_tc[k] = 0; n_inc[k] = 0; end
    for (int i = 0; i < NC; i++) n_ack[i] = 0;
    reset = 1'b1;
    bus.abrir = 1'b0; bus.finish = 1'b0;
    bus.valid = '0; bus.voto = '0; bus.swap = '0;
    repeat (2) step();
    reset = 1'b0;
    step();

    // open session
    bus.abrir = 1'b1; step();
    chk("open_clear_state", 32'(bus.estado), 1);
    chk("open_clear_pulse", 32'(bus.clear_tally), 1);
    bus.abrir = 1'b0; step();
    chk("open_voting", 32'(bus.estado), 2);

    // single held press counts once
    a0 = n_ack[0]; c0 = n_inc[0];
    booth(0, 1'b1, CA, 1'b0);
    repeat (5) step();
    booth(0, 1'b0, CA, 1'b0); step();
    chk("held_acks", n_ack[0] - a0, 1);
    chk("held_c1", n_inc[0] - c0, 1);

    // two simultaneous booths, both resolve to candidate 2
    c1b = n_inc[1];
    booth(0, 1'b1, CB, 1'b0); booth(1, 1'b1, CA, 1'b1);
    repeat (4) step();
    booth(0, 1'b0, CB, 1'b0); booth(1, 1'b0, CA, 1'b1); step();
    chk("pair_c2", n_inc[1] - c1b, 2);
    chk("full_flag", 32'(bus.urna_cheia), 1);

    // box full: press ignored
    a0 = n_ack[0];
    press(0, CA, 1'b0);
    chk("full_no_ack", n_ack[0] - a0, 0);
    chk("full_count", 32'(bus.cont_votos), 3);

    bus.finish = 1'b1; step(); bus.finish = 1'b0; step();
    chk("report_state", 32'(bus.estado), 4);

    // second session: null codes and swapped candidate 2
    bus.abrir = 1'b1; step(); bus.abrir = 1'b0; step();
    nb = n_inc[2]; c0 = n_inc[0];
    press(1, 4'b1110, 1'b0);
    press(1, 4'b1011, 1'b0);
    chk("null_twice", n_inc[2] - nb, 2);
    chk("null_count", 32'(bus.cont_votos), 2);
    press(1, CB, 1'b1);
    chk("swap_b_c1", n_inc[0] - c0, 1);
    bus.finish = 1'b1; step(); bus.finish = 1'b0; step();

    // finish together with a grant: pulse lands in the latch cycle
    bus.abrir = 1'b1; step(); bus.abrir = 1'b0; step();
    booth(0, 1'b1, CB, 1'b1); bus.finish = 1'b1;
    step();
    bus.finish = 1'b0; booth(0, 1'b0, CB, 1'b1);
    chk("fin_latch_state", 32'(bus.estado), 3);
    chk("fin_latch_pulse", 32'(bus.latch_totals), 1);
    chk("fin_inc_c1", 32'(bus.inc_c1), 1);
    chk("fin_tc_c1", t_tc[0], 1);
    step();
    chk("fin_report", 32'(bus.estado), 4);

    // reopen, then reset in the middle of voting
    bus.abrir = 1'b1; step();
    chk("reopen_cont", 32'(bus.cont_votos), 0);
    bus.abrir = 1'b0; step();
    booth(1, 1'b1, CA, 1'b0); step();
    reset = 1'b1; step();
    chk("rst_estado", 32'(bus.estado), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_inc", 32'({bus.inc_c1, bus.inc_c2, bus.inc_null}), 0);
    reset = 1'b0; booth(1, 1'b0, CA, 1'b0); step();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      bus.abrir  = ($urandom_range(0, 9) == 0);
      bus.finish = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NC; i++) begin
        if (!bus.valid[i]) begin
          case ($urandom_range(0, 3))
            0: bus.voto[4*i +: 4] = CA;
            1: bus.voto[4*i +: 4] = CB;
            default: bus.voto[4*i +: 4] = 4'($urandom_range(0, 15));
          endcase
          bus.swap[i] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 2) == 0) bus.valid[i] = ~bus.valid[i];
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
